divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a divide; the EX stage drives it when alucontrol decodes to DIV or DIVU.
REQ-005 signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 a  input  32  dividend (rs); sampled with start.
REQ-007 b  input  32  divisor (rt); sampled with start.
REQ-008 annul  input  1  abort in-flight operation (exception/flush).
REQ-009 result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-010 ready  output  1  one-cycle pulse; result valid.
REQ-011 stall  output  1  high while an operation is in flight; holds the pipeline.

Function
REQ-012 The FSM SHALL have four states: IDLE, DIVZERO, ON, END.
REQ-013 IDLE: start=1 accepted at edge T; it latches a, b and signed_div, then goes to DIVZERO if b==0, else to ON.
REQ-014 ON SHALL perform one radix-2 restoring iteration per cycle on 32-bit magnitudes, for 32 cycles (T+1..T+32), then go to END.
REQ-015 DIVZERO SHALL last one cycle (T+1), then go to END.
REQ-016 END SHALL last exactly one cycle: ready=1, result valid, then return to IDLE.
REQ-017 Latency: normal divide, ready at cycle T+33; divide-by-zero, ready at cycle T+2.
REQ-018 stall SHALL be 1 in states DIVZERO and ON.
REQ-019 stall SHALL be 1 in IDLE in the cycle start is asserted.
REQ-020 stall SHALL be 0 in END and otherwise in IDLE.
REQ-021 result SHALL be registered at entry to END and held until the next END; it is not cleared on return to IDLE.
REQ-022 Signed mode SHALL divide absolute values (two's-complement negation).
REQ-023 Signed mode: quotient negated iff a[31]^b[31]; remainder takes the sign of a.
REQ-024 Signed mode SHALL satisfy a = q*b + r with |r| < |b|, r = 0 allowed.
REQ-025 Overflow: signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-026 Divide-by-zero (either mode) SHALL give result = {a, 32'hFFFFFFFF}, with no exception.
REQ-027 start while not IDLE SHALL be ignored; operands SHALL not be re-sampled.
REQ-028 annul=1 in DIVZERO or ON SHALL return the FSM to IDLE next edge with no ready pulse and result unchanged.
REQ-029 annul has no effect in IDLE or END.
REQ-030 start and annul both high in IDLE: annul has no effect and start is accepted.
REQ-031 Internal arithmetic SHALL use a 33-bit partial remainder; no other width extension is visible at ports.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, result=64'h0, ready=0 and stall=0, independent of clk.
REQ-033 Reset mid-operation SHALL discard the operation; the first start after rst deasserts is accepted normally.

Verification
REQ-034 Unsigned 7/2, start at T: ready=1 only at T+33 and result=0x00000001_00000003; stall=1 from T through T+32.
REQ-035 Signed -7/2 (a=0xFFFFFFF9, b=2): result=0xFFFFFFFF_FFFFFFFD.
REQ-036 Signed 7/-2 (b=0xFFFFFFFE): result=0x00000001_FFFFFFFD.
REQ-037 Overflow edge, a=0x80000000, b=0xFFFFFFFF: signed gives 0x00000000_80000000; unsigned gives 0x80000000_00000000.
REQ-038 Divide-by-zero, a=0x12345678, b=0: ready at T+2 with result=0x12345678_FFFFFFFF.
REQ-039 Abort: annul at T+10 -> no ready pulse, stall=0 from T+11, result keeps previous value.
REQ-040 Reset: async rst at T+20 -> outputs cleared before next edge; a new start after release completes in 33 cycles.
REQ-041 Ignored start: start pulsed at T+5 during ON -> no effect on timing or result.

Source files
------------

// File: rtl/divider_if.sv
// Handshake and data bundle between the EX stage and the iterative divider.
interface divider_if;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    modport master (
        output start, signed_div, a, b, annul,
        input  result, ready, stall
    );

    modport slave (
        input  start, signed_div, a, b, annul,
        output result, ready, stall
    );
endinterface

// File: rtl/divider.sv
// Iterative 32-bit divider for the EX stage, handling DIV and DIVU.
// One radix-2 restoring step per cycle on operand magnitudes.
// Signs are applied when the final step is written into the result register.
// Divide-by-zero takes a short path that returns {a, all ones} without trapping.
module divider (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  count;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] result_q;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] q_final;
    logic [31:0] r_final;
    logic        unused_rem_msb;

    // Operand magnitudes: negate only negative signed operands (0x80000000 maps to itself).
    always_comb begin
        mag_a = (bus.signed_div && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
        mag_b = (bus.signed_div && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
    end

    // One restoring step: shift the next dividend bit in, keep the difference only if it stays non-negative.
    always_comb begin
        shifted = {rem[31:0], quo[31]};
        trial   = shifted - {1'b0, dvsr};
        if (!trial[32]) begin
            rem_next = trial;
            quo_next = {quo[30:0], 1'b1};
        end else begin
            rem_next = shifted;
            quo_next = {quo[30:0], 1'b0};
        end
        q_final = neg_q ? (~quo_next + 32'd1) : quo_next;
        r_final = neg_r ? (~rem_next[31:0] + 32'd1) : rem_next[31:0];
    end

    // After a restore the top bit is always clear, so it only matters inside the trial subtraction.
    assign unused_rem_msb = rem[32];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake outputs; stall rises combinationally with start so the pipeline holds at once.
    always_comb begin
        next_state = state;
        bus.stall  = 1'b0;
        bus.ready  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !rst) begin
                    bus.stall  = 1'b1;
                    next_state = (bus.b == 32'd0) ? DIVZERO : ON;
                end
            end
            DIVZERO: begin
                bus.stall  = 1'b1;
                next_state = bus.annul ? IDLE : END;
            end
            ON: begin
                bus.stall = 1'b1;
                if (bus.annul) begin
                    next_state = IDLE;
                end else if (count == 5'd31) begin
                    next_state = END;
                end
            end
            END: begin
                bus.ready  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in ON, write result only when entering END.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= 5'd0;
            rem      <= 33'd0;
            quo      <= 32'd0;
            dvsr     <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        quo   <= (bus.b == 32'd0) ? bus.a : mag_a;
                        dvsr  <= mag_b;
                        rem   <= 33'd0;
                        count <= 5'd0;
                        neg_q <= bus.signed_div & (bus.a[31] ^ bus.b[31]);
                        neg_r <= bus.signed_div & bus.a[31];
                    end
                end
                DIVZERO: begin
                    if (!bus.annul) begin
                        result_q <= {quo, 32'hFFFF_FFFF};
                    end
                end
                ON: begin
                    if (!bus.annul) begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            result_q <= {r_final, q_final};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result = result_q;

endmodule
